// File: rtl/disp_pkg.sv
// Shared seven-segment glyph table and converter state encoding
// for the counter/display block.
package disp_pkg;

  localparam logic DP_OFF = 1'b1;

  // {g,f,e,d,c,b,a} active-low, indexed by digit value (entry 0 listed last)
  localparam logic [15:0][6:0] SEG7_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    CV_IDLE   = 2'd0,
    CV_SHIFT  = 2'd1,
    CV_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    return {DP_OFF, SEG7_GLYPH[v]};
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, low NDIG digits out.
// Latency: W cycles after start; done marks the final shift, bcd is valid from the next cycle.
// Backpressure: none; start is ignored while busy.
module bin_to_bcd_seq #(
  parameter int W    = 8,
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      bin,
  output logic              busy,
  output logic              done,
  output logic [NDIG*4-1:0] bcd
);

  // Enough internal BCD digits to hold any W-bit value, independent of NDIG
  localparam int ND = (W + 2) / 3;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]    bin_sh;
  logic [ND*4-1:0] acc;
  logic [ND*4-1:0] acc_adj;
  logic [CW-1:0]   cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < ND; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      bin_sh <= '0;
    end else if (busy) begin
      {acc, bin_sh} <= {acc_adj, bin_sh} << 1;
      cnt           <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(W);
      acc    <= '0;
      bin_sh <= bin;
    end
  end

  assign done = busy && (cnt == CW'(1));

  generate
    if (NDIG <= ND) begin : g_bcd_trunc
      assign bcd = acc[NDIG*4-1:0];
    end else begin : g_bcd_pad
      assign bcd = {{((NDIG - ND) * 4){1'b0}}, acc};
    end
  endgenerate

endmodule

// File: rtl/counter_display_n.sv
// Debounced-button W-bit up/down counter driving an NDIG-digit muxed hex/decimal display.
// Latency: q to display register W+2 cycles (decimal) or 3 cycles (hex); debounce DB_CYCLES+2.
// Backpressure: none; q changes during a conversion are picked up by a follow-up conversion.
module counter_display_n
  import disp_pkg::*;
#(
  parameter int W            = 8,
  parameter int NDIG         = 4,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn,
  input  logic            en,
  input  logic            up,
  input  logic [W-1:0]    d,
  input  logic            syn_clr,
  input  logic            load,
  input  logic            hex_mode,
  output logic [W-1:0]    q,
  output logic            max_tick,
  output logic            min_tick,
  output logic [7:0]      sseg,
  output logic [NDIG-1:0] an
);

  localparam int DBW  = $clog2(DB_CYCLES);
  localparam int DW   = NDIG * 4;
  localparam int SELW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic           btn_s1, btn_s2, db_lvl, db_prev, step;
  logic [DBW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      db_prev <= db_lvl;
      if (btn_s2 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_lvl <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign step = db_lvl & ~db_prev;

  always_ff @(posedge clk) begin
    if (reset)          q <= '0;
    else if (syn_clr)   q <= '0;
    else if (load)      q <= d;
    else if (en & step) q <= up ? q + 1'b1 : q - 1'b1;
  end

  assign max_tick = (q == {W{1'b1}});
  assign min_tick = (q == '0);

  conv_state_t           state, state_nxt;
  logic                  pending, change, launch;
  logic [W-1:0]          q_seen;
  logic                  hex_seen, snap_hex;
  logic                  bcd_start, bcd_busy, bcd_done, commit;
  logic [DW-1:0]         hex_split, hex_dat, bcd_dat, commit_dat;
  logic [NDIG-1:0][3:0]  digit_reg;

  generate
    if (DW >= W) begin : g_hex_pad
      assign hex_split = DW'(q);
    end else begin : g_hex_trunc
      assign hex_split = q[DW-1:0];
    end
  endgenerate

  // A change seen while idle launches at once rather than waiting a cycle in pending
  assign change = (q != q_seen) || (hex_mode != hex_seen);
  assign launch = (state == CV_IDLE) && (pending || change);

  always_comb begin
    state_nxt = state;
    bcd_start = 1'b0;
    commit    = 1'b0;
    case (state)
      CV_IDLE: begin
        if (pending || change) begin
          bcd_start = !hex_mode && !bcd_busy;
          state_nxt = CV_SHIFT;
        end
      end
      CV_SHIFT:  if (snap_hex || bcd_done) state_nxt = CV_COMMIT;
      CV_COMMIT: begin
        commit    = 1'b1;
        state_nxt = CV_IDLE;
      end
      default:   state_nxt = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CV_IDLE;
    else       state <= state_nxt;
  end

  bin_to_bcd_seq #(.W(W), .NDIG(NDIG)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (q),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_dat)
  );

  assign commit_dat = snap_hex ? hex_dat : bcd_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b1;
      q_seen    <= '0;
      hex_seen  <= 1'b0;
      snap_hex  <= 1'b0;
      hex_dat   <= '0;
      digit_reg <= '0;
    end else begin
      q_seen   <= q;
      hex_seen <= hex_mode;
      if (launch) begin
        pending  <= 1'b0;
        snap_hex <= hex_mode;
        hex_dat  <= hex_split;
      end else if (change) begin
        pending  <= 1'b1;
      end
      if (commit) digit_reg <= commit_dat;
    end
  end

  logic [REFRESH_BITS-1:0] refresh;
  logic [SELW-1:0]         sel;

  always_ff @(posedge clk) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + 1'b1;
  end

  assign sel = (NDIG > 1) ? refresh[REFRESH_BITS-1 -: SELW] : '0;

  // Select codes past the last digit blank the whole display
  always_comb begin
    an   = '1;
    sseg = '1;
    if (int'(sel) < NDIG) begin
      an[sel] = 1'b0;
      sseg    = seg7(digit_reg[sel]);
    end
  end

endmodule

// File: tb/tb_counter_display_n.sv
// Scoreboarded bench for counter_display_n: expected display commits are queued by the
// stimulus and popped by a monitor whenever the converter commits.
module tb_counter_display_n;
  import disp_pkg::*;

  logic       clk = 1'b0;
  logic       reset, btn, en, up, syn_clr, load, hex_mode;
  logic [7:0] d, q, sseg;
  logic [2:0] an;
  logic       max_tick, min_tick;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  counter_display_n #(.W(8), .NDIG(3), .DB_CYCLES(4), .REFRESH_BITS(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .en(en), .up(up), .d(d),
    .syn_clr(syn_clr), .load(load), .hex_mode(hex_mode), .q(q),
    .max_tick(max_tick), .min_tick(min_tick), .sseg(sseg), .an(an)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_disp(input int v, input bit hx);
    logic [11:0] r;
    if (hx) r = {4'h0, 4'(v / 16), 4'(v % 16)};
    else    r = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic load_val(input logic [7:0] v);
    load = 1'b1;
    d    = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (8) @(negedge clk);
    btn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    logic [2:0] scan_exp [4];
    logic [2:0] prev_an;
    int bad;
    bit found;
    scan_exp = '{3'b110, 3'b101, 3'b011, 3'b111};

    fork
      forever begin
        @(negedge clk);
        if (!reset && dut.commit) begin
          if (exp_q.size() == 0) begin
            chk("commit_unexpected", 32'(dut.commit_dat), 32'hFFFFFFFF);
          end else begin
            chk("commit_value", 32'(dut.commit_dat), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    reset = 1'b1; btn = 1'b0; en = 1'b1; up = 1'b1; d = '0;
    syn_clr = 1'b0; load = 1'b0; hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_min", min_tick, 1);
    chk("rst_max", max_tick, 0);
    chk("rst_an", an, 3'b110);
    chk("rst_sseg", sseg, 8'hC0);
    chk("rst_state", 32'(dut.state), 32'(CV_IDLE));
    exp_q.push_back(exp_disp(0, 0));
    reset = 1'b0;
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (an != 3'b111 && sseg != 8'hC0) bad++;
    end
    chk("reset_glyphs", bad, 0);

    // Bouncy press: exactly one step
    exp_q.push_back(exp_disp(1, 0));
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (2) @(negedge clk);
    btn = 1'b1; repeat (10) @(negedge clk);
    chk("bounce_q", q, 8'd1);
    btn = 1'b0; repeat (14) @(negedge clk);
    chk("release_q", q, 8'd1);

    // Wrap in both directions
    exp_q.push_back(exp_disp(255, 0));
    load_val(8'hFF);
    chk("load_ff_q", q, 8'hFF);
    chk("load_ff_max", max_tick, 1);
    chk("load_ff_min", min_tick, 0);
    repeat (12) @(negedge clk);
    exp_q.push_back(exp_disp(0, 0));
    press();
    chk("wrap_up_q", q, 8'h00);
    chk("wrap_up_min", min_tick, 1);
    up = 1'b0;
    exp_q.push_back(exp_disp(255, 0));
    press();
    chk("wrap_dn_q", q, 8'hFF);
    chk("wrap_dn_max", max_tick, 1);
    en = 1'b0;
    press();
    chk("en_off_q", q, 8'hFF);
    en = 1'b1; up = 1'b1;

    // Decimal then hex rendering of 255
    exp_q.push_back(exp_disp(0, 0));
    load_val(8'd0);
    repeat (12) @(negedge clk);
    exp_q.push_back(exp_disp(255, 0));
    load_val(8'd255);
    repeat (10) @(negedge clk);
    chk("dec_255", 32'(dut.digit_reg), 32'h255);
    exp_q.push_back(exp_disp(255, 1));
    hex_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("hex_0ff", 32'(dut.digit_reg), 32'h0FF);
    exp_q.push_back(exp_disp(255, 0));
    hex_mode = 1'b0;
    repeat (12) @(negedge clk);

    // Reload mid-conversion: 100 completes, then 37
    exp_q.push_back(exp_disp(100, 0));
    exp_q.push_back(exp_disp(37, 0));
    load_val(8'd100);
    @(negedge clk);
    load_val(8'd37);
    repeat (25) @(negedge clk);
    chk("settle_037", 32'(dut.digit_reg), 32'h037);

    // Reset in the middle of a conversion
    load_val(8'd200);
    repeat (3) @(negedge clk);
    chk("mid_shift", 32'(dut.state), 32'(CV_SHIFT));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(dut.state), 32'(CV_IDLE));
    chk("rst_mid_digits", 32'(dut.digit_reg), 0);
    chk("rst_mid_q", q, 0);
    exp_q.push_back(exp_disp(0, 0));
    reset = 1'b0;
    repeat (14) @(negedge clk);

    // syn_clr beats load beats step
    exp_q.push_back(exp_disp(5, 0));
    load_val(8'd5);
    repeat (12) @(negedge clk);
    exp_q.push_back(exp_disp(0, 0));
    syn_clr = 1'b1; load = 1'b1; d = 8'h55;
    press();
    syn_clr = 1'b0; load = 1'b0;
    chk("clr_prio_q", q, 0);

    // Digit scan order with blank slot
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 3'b111 && an == 3'b110) found = 1'b1;
      else prev_an = an;
    end
    chk("scan_align", found, 1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        chk("scan_an", an, scan_exp[i / 4]);
        if (i == 4)  chk("scan_d1_sseg", sseg, 8'hC0);
        if (i == 12) chk("blank_sseg", sseg, 8'hFF);
        @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/counter_display_n.md
Name: counter_display_n

Overview:
- Parametrised successor to the 4-bit debounced counter/display block.
- A button input is debounced and edge-detected in the `clk` domain. The resulting pulse steps a W-bit universal counter (clear/load/up/down/enable).
- The counter value is shown on an NDIG-digit multiplexed seven-segment display, in hex or decimal mode. Decimal uses a sequential binary-to-BCD converter.
- Sits between board buttons/switches and the seven-segment/anode pins. The counter is never clocked from a debounced signal.

Parameters:
- W, 8, counter width in bits (2..16).
- NDIG, 4, number of display digits (1..8).
- DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a new button level (>=2).
- REFRESH_BITS, 18, refresh counter width; digit select is the top clog2(NDIG) bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn  in  1  raw, asynchronous step button
- en  in  1  count enable
- up  in  1  1 = count up, 0 = count down
- d  in  W  parallel load value
- syn_clr  in  1  synchronous clear
- load  in  1  synchronous load
- hex_mode  in  1  1 = hex display, 0 = decimal display
- q  out  W  counter value
- max_tick  out  1  high while q == 2^W-1
- min_tick  out  1  high while q == 0
- sseg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)
- an  out  NDIG  digit enables, one-hot, active-low

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high on `reset`. All state is cleared by reset, including mid-conversion or mid-debounce.
- Reset values:
  - q = 0, so min_tick = 1 and max_tick = 0.
  - Debounced level = 0; step = 0.
  - Converter in IDLE with pending = 1, so the first conversion starts on the cycle after reset releases.
  - Display digit register = all zeros; refresh counter = 0.
  - an = ~1 (digit 0 active); sseg = pattern for "0".
- Debounce:
  - btn passes through a 2-FF synchroniser.
  - The debounced level changes only after the synchronised input differs from it for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - step is a one-cycle pulse on a 0->1 transition of the debounced level. Release produces no pulse.
- Counter:
  - Updates on clk, priority syn_clr > load > (en & step).
  - Counting up wraps 2^W-1 -> 0; counting down wraps 0 -> 2^W-1.
  - load and syn_clr act without step and without en.
  - max_tick and min_tick are decoded combinationally from q.
- Converter FSM: states IDLE, SHIFT, COMMIT.
  - A change of q or hex_mode sets pending.
  - IDLE & pending: clear pending, snapshot q and hex_mode, go to SHIFT.
  - SHIFT, decimal mode: run double-dabble for exactly W cycles (add-3 on BCD nibbles >=5, then shift).
  - SHIFT, hex mode: takes 1 cycle (nibble split; digits above ceil(W/4) = 0).
  - COMMIT: write all NDIG digits to the display register atomically, then return to IDLE.
  - If q changes during SHIFT, the current conversion completes. pending then forces a fresh conversion. The display never shows a partially converted value.
  - Decimal latency from q update to display register: W+2 cycles worst case with no pending.
  - Decimal values needing more than NDIG digits show only the low NDIG digits.
- Display mux:
  - The refresh counter free-runs.
  - Select value k drives an[k] = 0 and sseg = seg7(digit[k]).
  - Select values >= NDIG (non-power-of-2 NDIG) blank the display: an all 1, sseg all 1.
  - Digit values 0-F use standard hex glyphs.

Decomposition:
- Package `disp_pkg`: the 16-entry seven-segment glyph constant (active-low), converter state enum, `DP_OFF` constant.
- One sub-module, `bin_to_bcd_seq`: start/busy/done handshake, W-bit input, NDIG*4-bit output, used for decimal mode.
- Debouncer, counter and mux stay inline in `counter_display_n`.

Test Plan:
All scenarios use W=8, NDIG=3, DB_CYCLES=4, REFRESH_BITS=4.
1. Reset -> q=0, min_tick=1, max_tick=0. After 10 cycles, every active digit shows glyph "0" (8'hC0).
2. btn bounces 1,0,1 for 2 cycles each, then holds 1 for 6 cycles, with en=1, up=1 -> exactly one step; q=1. Releasing btn gives no step.
3. load=1, d=8'hFF, then one step with up=1 -> q=8'hFF (max_tick=1) after load, then q=0 (min_tick=1) after step. Repeat with up=0 from 0 -> q=8'hFF.
4. Load 8'd255 with hex_mode=0 -> within 10 cycles the digits read 2,5,5. Switch hex_mode=1 -> digits read 0,F,F within 3 cycles.
5. Load 8'd100, then load 8'd37 two cycles later, mid-conversion -> display goes to 100 (or directly to 37), never any other value, and settles at 0,3,7. Assert on every COMMIT.
6. syn_clr and load asserted together with a step -> q=0. Reset asserted mid-SHIFT -> next cycle state=IDLE, display register = 0. Scan shows an cycling 110,101,011, then blank (111) for select 3.
